// File: rtl/sparse_poly_mult_dummy.sv
// Sparse-by-dense GF(2) multiplier mod x^N-1 with a seeded, constant-length dummy-slot schedule.
// state | meaning -- IDLE: wait for load_i | RUN: one real/dummy slot per cycle | DONE: done_o pulse, data_o valid
module sparse_poly_mult_dummy #(
  parameter  int N     = 128,
  parameter  int W     = 8,
  parameter  int D     = 8,
  localparam int LOG_N = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [W*LOG_N-1:0] key_i,
  input  logic [N-1:0]       data_i,
  input  logic [15:0]        seed_i,
  input  logic               dummy_en_i,
  output logic [N-1:0]       data_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int SW = $clog2(W + D + 1);
  localparam int RW = $clog2(W + 1);
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [N-1:0]       a_q;
  logic [W*LOG_N-1:0] key_q;
  logic               den_q;
  logic [15:0]        lfsr;
  logic [N-1:0]       acc;
  (* keep *) logic [N-1:0] dummy_acc;
  logic [SW-1:0]      slot_cnt;
  logic [RW-1:0]      real_cnt;

  logic [SW-1:0]      slots_total;
  logic [SW-1:0]      rem_real;
  logic [SW-1:0]      rem_slots;
  logic               is_real;
  logic               last_slot;
  logic [LOG_N-1:0]   p_real;
  logic [LOG_N-1:0]   p_dummy;
  logic [LOG_N-1:0]   rot_pos;
  logic [N-1:0]       rot_val;
  logic [N-1:0]       acc_nxt;
  logic [15:0]        lfsr_nxt;

  function automatic logic [LOG_N-1:0] reduce_pos(input logic [LOG_N-1:0] v);
    if ({1'b0, v} >= (LOG_N+1)'(N))
      return v - LOG_N'(N);
    else
      return v;
  endfunction

  // Upper half of the doubled word shifted left is exactly the cyclic rotation.
  function automatic logic [N-1:0] rotl(input logic [N-1:0] a, input logic [LOG_N-1:0] p);
    logic [2*N-1:0] t;
    t = {a, a} << p;
    return t[2*N-1:N];
  endfunction

  always_comb begin
    slots_total = den_q ? SW'(W + D) : SW'(W);
    rem_real    = SW'(W) - SW'(real_cnt);
    rem_slots   = slots_total - slot_cnt;
    if (rem_real == rem_slots)
      is_real = 1'b1;
    else if (rem_real == '0)
      is_real = 1'b0;
    else
      is_real = lfsr[0];
    last_slot = (slot_cnt == slots_total - SW'(1));
  end

  always_comb begin
    p_real = '0;
    for (int k = 0; k < W; k++) begin
      if (real_cnt == RW'(k))
        p_real = key_q[k*LOG_N +: LOG_N];
    end
    p_dummy = lfsr[LOG_N:1];
  end

  // Single shared shifter: real and dummy slots drive identical datapath activity.
  always_comb begin
    rot_pos  = is_real ? reduce_pos(p_real) : reduce_pos(p_dummy);
    rot_val  = rotl(a_q, rot_pos);
    acc_nxt  = is_real ? (acc ^ rot_val) : acc;
    lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      IDLE: begin
        if (load_i)
          state_nxt = RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (last_slot)
          state_nxt = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      key_q     <= '0;
      den_q     <= 1'b0;
      lfsr      <= SEED_DEFAULT;
      acc       <= '0;
      dummy_acc <= '0;
      slot_cnt  <= '0;
      real_cnt  <= '0;
      data_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_i) begin
            a_q       <= data_i;
            key_q     <= key_i;
            den_q     <= dummy_en_i;
            lfsr      <= (seed_i == 16'h0000) ? SEED_DEFAULT : seed_i;
            acc       <= '0;
            dummy_acc <= '0;
            slot_cnt  <= '0;
            real_cnt  <= '0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          if (is_real)
            real_cnt <= real_cnt + RW'(1);
          else
            dummy_acc <= dummy_acc ^ rot_val;
          slot_cnt <= slot_cnt + SW'(1);
          lfsr     <= lfsr_nxt;
          if (last_slot)
            data_o <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_poly_mult_dummy.sv
// Randomised and directed bench for sparse_poly_mult_dummy against a bit-level product model.
module tb_sparse_poly_mult_dummy;

  localparam int N     = 128;
  localparam int W     = 8;
  localparam int D     = 8;
  localparam int LOG_N = $clog2(N);

  logic               clk = 1'b0;
  logic               rst;
  logic               load_i;
  logic [W*LOG_N-1:0] key_i;
  logic [N-1:0]       data_i;
  logic [15:0]        seed_i;
  logic               dummy_en_i;
  logic [N-1:0]       data_o;
  logic               busy_o;
  logic               done_o;

  int total = 0;
  int bad   = 0;

  sparse_poly_mult_dummy #(.N(N), .W(W), .D(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_i),
    .key_i      (key_i),
    .data_i     (data_i),
    .seed_i     (seed_i),
    .dummy_en_i (dummy_en_i),
    .data_o     (data_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] rot_model(input logic [N-1:0] a, input int p);
    logic [N-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++)
      r[(j + p) % N] = a[j];
    return r;
  endfunction

  function automatic logic [N-1:0] prod_model(input logic [N-1:0] a, input logic [W*LOG_N-1:0] k);
    logic [N-1:0] c;
    int p;
    c = '0;
    for (int f = 0; f < W; f++) begin
      p = int'(k[f*LOG_N +: LOG_N]);
      if (p >= N) p = p - N;
      c = c ^ rot_model(a, p);
    end
    return c;
  endfunction

  task automatic chk_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [W*LOG_N-1:0] k,
                        input logic [15:0] s, input logic den, input logic glitch,
                        output logic [N-1:0] res);
    int width;
    int cyc;
    int extra;
    logic [N-1:0] exp;
    exp = prod_model(a, k);
    @(negedge clk);
    data_i = a; key_i = k; seed_i = s; dummy_en_i = den; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    width = 0;
    cyc = 0;
    while (done_o !== 1'b1 && cyc < 100) begin
      if (busy_o === 1'b1) width++;
      load_i = glitch && (cyc == 3);
      if (glitch && cyc == 3) begin
        data_i = ~a;
        key_i  = ~k;
      end
      @(negedge clk);
      cyc++;
    end
    load_i = 1'b0;
    chk_int({tag, "_done"}, int'(done_o), 1);
    chk_int({tag, "_busy_in_done"}, int'(busy_o), 0);
    chk_int({tag, "_busy_width"}, width, den ? W + D : W);
    chk_vec({tag, "_data"}, data_o, exp);
    chk_int({tag, "_real_slots"}, int'(dut.real_cnt), W);
    res = data_o;
    @(negedge clk);
    chk_int({tag, "_done_pulse"}, int'(done_o), 0);
    if (glitch) begin
      extra = 0;
      for (int c = 0; c < 20; c++) begin
        if (done_o === 1'b1 || busy_o === 1'b1) extra++;
        @(negedge clk);
      end
      chk_int({tag, "_no_extra_op"}, extra, 0);
      chk_vec({tag, "_data_held"}, data_o, exp);
    end
  endtask

  initial begin
    logic [N-1:0]       a;
    logic [W*LOG_N-1:0] k;
    logic [N-1:0]       r0;
    logic [N-1:0]       r1;
    int                 vals [W];
    int                 busy_seen;

    rst = 1'b1; load_i = 1'b1; key_i = '0; data_i = '1; seed_i = 16'h1234; dummy_en_i = 1'b1;
    busy_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy_o !== 1'b0) busy_seen++;
    end
    chk_vec("reset_data", data_o, '0);
    chk_int("reset_busy", int'(busy_o), 0);
    chk_int("reset_done", int'(done_o), 0);
    chk_int("reset_no_start", busy_seen, 0);
    rst = 1'b0; load_i = 1'b0;
    @(negedge clk);
    chk_int("post_reset_idle", int'(busy_o), 0);

    // Basic product: fields 0..7 on a=1 give 0xFF.
    for (int f = 0; f < W; f++) k[f*LOG_N +: LOG_N] = LOG_N'(f);
    a = '0; a[0] = 1'b1;
    run_op("basic", a, k, 16'h1234, 1'b1, 1'b0, r0);
    chk_vec("basic_const", r0, 128'hFF);

    // Wrap with all-equal fields: even count cancels.
    a = '0; a[N-1] = 1'b1;
    for (int f = 0; f < W; f++) k[f*LOG_N +: LOG_N] = LOG_N'(1);
    run_op("cancel", a, k, 16'h0042, 1'b1, 1'b0, r0);
    chk_vec("cancel_const", r0, '0);

    vals = '{1, 0, 0, 2, 2, 3, 3, 4};
    for (int f = 0; f < W; f++) k[f*LOG_N +: LOG_N] = LOG_N'(vals[f]);
    run_op("wrap", a, k, 16'h0007, 1'b1, 1'b0, r0);
    chk_vec("wrap_const", r0, 128'h9);

    // Constant time across seeds and dummy enable.
    a = {$urandom, $urandom, $urandom, $urandom};
    for (int f = 0; f < W; f++) k[f*LOG_N +: LOG_N] = LOG_N'($urandom_range(0, N - 1));
    run_op("seed1", a, k, 16'h0001, 1'b1, 1'b0, r0);
    run_op("seedbeef", a, k, 16'hBEEF, 1'b1, 1'b0, r1);
    chk_vec("seed_equal_beef", r1, r0);
    run_op("seed0", a, k, 16'h0000, 1'b1, 1'b0, r1);
    chk_vec("seed_equal_zero", r1, r0);
    run_op("nodummy", a, k, 16'h5A5A, 1'b0, 1'b0, r1);
    chk_vec("nodummy_equal", r1, r0);

    // Handshake: load during RUN is ignored.
    a = {$urandom, $urandom, $urandom, $urandom};
    for (int f = 0; f < W; f++) k[f*LOG_N +: LOG_N] = LOG_N'($urandom_range(0, N - 1));
    run_op("handshake", a, k, 16'h3C3C, 1'b1, 1'b1, r0);

    // Abort at RUN slot 5, then a clean operation.
    @(negedge clk);
    data_i = {$urandom, $urandom, $urandom, $urandom}; seed_i = 16'h0099; dummy_en_i = 1'b1;
    load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    repeat (5) @(negedge clk);
    chk_int("abort_busy_before", int'(busy_o), 1);
    rst = 1'b1;
    #1;
    chk_int("abort_busy", int'(busy_o), 0);
    chk_vec("abort_data", data_o, '0);
    chk_int("abort_done", int'(done_o), 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_abort", a, k, 16'h0099, 1'b1, 1'b0, r1);

    // Random operations.
    for (int t = 0; t < 6; t++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      for (int f = 0; f < W; f++) k[f*LOG_N +: LOG_N] = LOG_N'($urandom_range(0, N - 1));
      run_op("random", a, k, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, r0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sparse_poly_mult_dummy.md
# sparse_poly_mult_dummy

Parametrised sparse-by-dense polynomial multiplier over GF(2) modulo x^N−1, with constant-time dummy-slot insertion as a side-channel countermeasure. It replaces the fixed-width multiplier core behind the CW305 register block. It keeps the same load/busy handshake, generalises ring size, sparse weight and dummy count, and adds a seeded dummy schedule and a done pulse. The block sits between the register front-end (key → sparse operand, text → dense operand, cipher ← product) and the trigger output.

## Interface
- N, 128: ring degree; product is a·h mod (x^N−1).
- W, 8: sparse weight, i.e. number of position fields in key_i.
- D, 8: dummy slots per operation.
- LOG_N, $clog2(N): derived localparam; width of one position field.
- clk  in  1  core clock (crypto clock domain).
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- load_i  in  1  start request, sampled only in IDLE.
- key_i  in  W*LOG_N  sparse operand h; field k = key_i[k*LOG_N +: LOG_N] is the exponent of the k-th term.
- data_i  in  N  dense operand a; bit j = coefficient of x^j.
- seed_i  in  16  LFSR seed for the dummy schedule.
- dummy_en_i  in  1  1: S=W+D slots; 0: S=W slots, no dummies.
- data_o  out  N  product c, held until the next completion.
- busy_o  out  1  high while an operation is in progress.
- done_o  out  1  one-cycle pulse when data_o updates.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with load_i=1:
  - latch data_i, key_i and dummy_en_i; S is fixed for the whole operation.
  - seed the LFSR with seed_i, substituting 16'hACE1 when seed_i==0.
  - clear acc, dummy_acc, slot counter i and real counter r.
  - go to RUN.
- RUN, one slot per cycle:
  - rem_real = W−r, rem_slots = S−i.
  - The slot is real if rem_real==rem_slots, dummy if rem_real==0, otherwise real when lfsr[0]==1.
  - Real slot: acc ^= rotl(a, p_r) with p_r = key field r; then r++.
  - Dummy slot: dummy_acc ^= rotl(a, p_d) with p_d = lfsr[LOG_N:1].
  - i++ and the LFSR advances every RUN cycle, whether the slot is real or dummy.
  - After slot S−1, go to DONE.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts left with feedback into bit 0.
- rotl(a,p): bit j moves to bit (j+p) mod N, i.e. multiplication by x^p.
- Position reduction: a field value ≥ N is reduced to value−N by a single conditional subtract. This applies to both p_r and p_d. It is a no-op when N is a power of two.
- Duplicate positions cancel (XOR), as in GF(2) arithmetic.
- Exactly W real slots execute per operation regardless of seed or key.
- dummy_acc is never output and carries a keep attribute so synthesis does not remove it.
- DONE: data_o <= acc, done_o=1, then return to IDLE.
- load_i in RUN or DONE is ignored; there is no queuing.

## Timing
- Reset values: data_o=0, busy_o=0, done_o=0, state=IDLE, counters 0, LFSR 16'hACE1.
- rst asserted mid-operation aborts immediately: outputs go to reset values and the result is discarded.
- With load_i accepted at edge T:
  - busy_o is high from T+1 through T+S (S cycles, the RUN cycles).
  - busy_o is low at T+S+1, which is the DONE cycle: done_o=1 and data_o is valid.
  - Earliest next load acceptance is the edge ending DONE+1 (IDLE).
- Latency is constant for a given dummy_en_i. It is independent of key, data and seed.
- The rotation is a combinational barrel shifter on the latched a. Its result is XORed into acc in the same cycle; there are no pipeline stages.

## Test plan
- Reset: hold rst 3 cycles with load_i=1 → data_o=0, busy_o=0, done_o=0; no operation starts until after rst deasserts.
- Basic product: N=128, W=8, D=8, dummy_en_i=1, data_i=1, key fields {0,1,...,7}, seed 16'h1234 → busy_o high 16 cycles, then done_o pulse with data_o=128'hFF.
- Wrap and cancel:
  - data_i=1<<127, all fields=1 → data_o=0 (even duplicates cancel).
  - Fields {1,0,0,2,2,3,3,4,4} truncated to W=8 as {1,0,0,2,2,3,3,4} → data_o = rotl(a,1)^rotl(a,4) = bit0 | bit3.
- Constant time: same operands with seeds 1, 16'hBEEF and 0 → identical data_o, busy_o width 16 each time. With dummy_en_i=0 → width 8 and identical data_o. Checker counts real slots = 8 in every run.
- Handshake: pulse load_i during RUN with different data → ignored; result matches the first operands; exactly one done_o pulse.
- Abort: assert rst at RUN slot 5 → busy_o=0 and data_o=0 immediately; a subsequent load completes normally with the correct product.
